// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM encoding and default width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/mul_magnitude.sv
// Combinational conditional two's-complement negate.
module mul_magnitude #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/seq_signed_multiplier.sv
// Iterative shift-add multiplier, signed or unsigned, start/done handshake.
module seq_signed_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_fix;
    logic [WIDTH:0]     sum;
    logic               neg_a;
    logic               neg_b;

    assign neg_a = is_signed & a[WIDTH-1];
    assign neg_b = is_signed & b[WIDTH-1];

    mul_magnitude #(.W(WIDTH)) u_mag_a (
        .x   (a),
        .neg (neg_a),
        .y   (mag_a)
    );

    mul_magnitude #(.W(WIDTH)) u_mag_b (
        .x   (b),
        .neg (neg_b),
        .y   (mag_b)
    );

    mul_magnitude #(.W(2*WIDTH)) u_mag_p (
        .x   (acc),
        .neg (neg),
        .y   (acc_fix)
    );

    // Carry out of the upper half lands in the top bit after the shift.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (mplier[0] ? mcand : '0)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= neg_a ^ neg_b;
                        acc    <= '0;
                        count  <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    product <= acc_fix;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scoreboard bench for seq_signed_multiplier: directed corners plus random ops.
module tb_seq_signed_multiplier;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_run = 0;
    int done_total = 0;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];

    seq_signed_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_mul(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         s
    );
        logic signed [2*W-1:0] ex;
        logic signed [2*W-1:0] ey;
        ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return ex * ey;
    endfunction

    task automatic chk(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports done.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                done_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got product %h with empty queue",
                             product);
                end else begin
                    logic [2*W-1:0] e;
                    int             c0;
                    e  = exp_q.pop_front();
                    c0 = acc_q.pop_front();
                    chk("product", product, e);
                    chk("latency", 2*W'(cyc - c0), 2*W'(LAT));
                    chk("busy_in_done", 2*W'(busy), '0);
                    chk("busy_cycles", 2*W'(busy_run), 2*W'(LAT));
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input bit expect_it);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        is_signed = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_it) begin
            exp_q.push_back(ref_mul(x, y, s));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!done && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required one", g);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int seen;
        int g;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 2*W'(busy), '0);
        chk("reset_done", 2*W'(done), '0);
        chk("reset_product", product, '0);
        rst = 1'b0;

        issue(32'd7, -32'sd3, 1'b1, 1'b1);
        wait_done();
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done();
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
        wait_done();
        issue(32'h0, 32'h1234_5678, 1'b1, 1'b1);
        wait_done();

        // Second start while busy must be dropped.
        base = done_total;
        issue(32'd5, 32'd6, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        issue(32'd9, 32'd9, 1'b0, 1'b0);
        wait_done();
        repeat (40) @(posedge clk);
        #1;
        chk("busy_protect_dones", 2*W'(done_total - base), 2*W'(1));

        // Continuous start: one result every W+2 cycles.
        @(posedge clk);
        #1;
        a = '1;
        b = '1;
        is_signed = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ref_mul('1, '1, 1'b1));
            acc_q.push_back(cyc + k * (W + 2));
        end
        seen = 0;
        g = 0;
        while (seen < 3 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
            if (done) seen++;
        end
        start = 1'b0;
        chk("b2b_pulses", 2*W'(seen), 2*W'(3));

        // Abort mid-operation; product must clear and no done may appear.
        issue(32'd11, 32'd13, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 2*W'(busy), '0);
        chk("abort_done", 2*W'(done), '0);
        chk("abort_product", product, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        issue(32'd3, 32'd4, 1'b0, 1'b1);
        wait_done();

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         s;
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 6 == 0) x = {1'b1, {(W-1){1'b0}}};
            if (i % 7 == 0) y = '1;
            issue(x, y, s, 1'b1);
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 2*W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
